// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with busywait handshake to data memory
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           store_data,
    output logic                  busywait,
    output logic                  access_error,
    output logic [31:0]           load_data,
    output logic                  dmem_read,
    output logic                  dmem_write,
    output logic [ADDR_WIDTH-3:0] dmem_address,
    output logic [31:0]           dmem_writedata,
    output logic [3:0]            dmem_byteen,
    input  logic [31:0]           dmem_readdata,
    input  logic                  dmem_busywait
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state_q, state_d;
    logic                  first_q, first_d;
    logic [1:0]            offset_q, offset_d;
    logic [31:0]           load_data_q, load_data_d;
    logic                  dmem_read_q, dmem_read_d;
    logic                  dmem_write_q, dmem_write_d;
    logic [ADDR_WIDTH-3:0] dmem_address_q, dmem_address_d;
    logic [31:0]           dmem_writedata_q, dmem_writedata_d;
    logic [3:0]            dmem_byteen_q, dmem_byteen_d;
    logic [1:0]            offset;
    logic                  req, legal, legal_req;

    always_comb begin
        offset = address[1:0];
        req = mem_read ^ mem_write;
        legal = mem_read
            ? (func3 == 3'b000 || func3 == 3'b100 ||
               ((func3 == 3'b001 || func3 == 3'b101) && !offset[0]) ||
               (func3 == 3'b010 && offset == 2'b00))
            : (func3 == 3'b000 ||
               (func3 == 3'b001 && !offset[0]) ||
               (func3 == 3'b010 && offset == 2'b00));
        legal_req = req && legal;
        access_error = !reset && state_q == IDLE && (mem_read || mem_write) && !legal_req;
        busywait = !reset && ((state_q == IDLE && legal_req) || state_q == ACCESS);
        state_d = state_q;
        first_d = first_q;
        offset_d = offset_q;
        load_data_d = load_data_q;
        dmem_read_d = dmem_read_q;
        dmem_write_d = dmem_write_q;
        dmem_address_d = dmem_address_q;
        dmem_writedata_d = dmem_writedata_q;
        dmem_byteen_d = dmem_byteen_q;
        case (state_q)
            IDLE: if (legal_req) begin
                state_d = ACCESS;
                first_d = 1'b1;
                offset_d = offset;
                dmem_address_d = address[ADDR_WIDTH-1:2];
                dmem_read_d = mem_read;
                dmem_write_d = mem_write;
                dmem_byteen_d = !mem_write ? 4'b0000 :
                                func3[1] ? 4'b1111 :
                                func3[0] ? 4'b0011 << offset : 4'b0001 << offset;
                dmem_writedata_d = !mem_write ? dmem_writedata_q :
                                   func3[1] ? store_data :
                                   func3[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
            end
            ACCESS: begin
                first_d = 1'b0;
                // memory busywait lags the strobe by a cycle, so the first cycle cannot complete
                if (!first_q && !dmem_busywait) begin
                    state_d = DONE;
                    load_data_d = dmem_read_q ? dmem_readdata >> {offset_q, 3'b000} : load_data_q;
                    dmem_read_d = 1'b0;
                    dmem_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            offset_q <= 2'b00;
            load_data_q <= '0;
            dmem_read_q <= 1'b0;
            dmem_write_q <= 1'b0;
            dmem_address_q <= '0;
            dmem_writedata_q <= '0;
            dmem_byteen_q <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            offset_q <= offset_d;
            load_data_q <= load_data_d;
            dmem_read_q <= dmem_read_d;
            dmem_write_q <= dmem_write_d;
            dmem_address_q <= dmem_address_d;
            dmem_writedata_q <= dmem_writedata_d;
            dmem_byteen_q <= dmem_byteen_d;
        end
    end

    assign load_data = load_data_q;
    assign dmem_read = dmem_read_q;
    assign dmem_write = dmem_write_q;
    assign dmem_address = dmem_address_q;
    assign dmem_writedata = dmem_writedata_q;
    assign dmem_byteen = dmem_byteen_q;
endmodule
